// File: rtl/pe_horner.sv
// pe_horner: systolic-array processing element with two personalities.
//
//   GEMM mode (gemm_uno == 00): weight/activation are registered and forwarded to the
//   neighbouring PEs every cycle; the partial sum accumulates sext(w)*sext(x) + o_i.
//
//   Unary modes (div/exp/log): a Horner polynomial engine. The argument x is latched on
//   start_i, then N+1 coefficients (highest order first) stream in over a valid/ready
//   handshake. Every iteration saturates the running value back to Q(INT_BW.FRA_BW)
//   before multiplying by x, so the accumulator never carries more than one product.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   gemm_uno            mode: 00 gemm, 01 div, 10 exp, 11 log
//   x_i / x_o           activation in / registered activation out
//   wc_i / wc_o         weight in / registered weight out
//   o_i / o_o           partial sum in / registered partial sum out
//   start_i, iters_i    start a unary evaluation of degree iters_i (clamped to ITER_MAX)
//   busy_o              FSM not idle
//   coef_i, coef_valid_i, coef_ready_o   coefficient stream
//   res_o, res_op_o, res_valid_o, res_ready_i   result and the op that produced it

module pe_horner #(
  parameter int unsigned INT_BW   = 5,
  parameter int unsigned FRA_BW   = 10,
  parameter int unsigned MUL_BW   = 16,
  parameter int unsigned ACC_BW   = 32,
  parameter int unsigned ITER_MAX = 8,
  parameter int unsigned CNT_BW   = $clog2(ITER_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        gemm_uno,
  input  logic [MUL_BW-1:0] x_i,
  input  logic [MUL_BW-1:0] wc_i,
  input  logic [ACC_BW-1:0] o_i,
  output logic [MUL_BW-1:0] x_o,
  output logic [MUL_BW-1:0] wc_o,
  output logic [ACC_BW-1:0] o_o,
  input  logic              start_i,
  input  logic [CNT_BW-1:0] iters_i,
  output logic              busy_o,
  input  logic [MUL_BW-1:0] coef_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  output logic [MUL_BW-1:0] res_o,
  output logic [1:0]        res_op_o,
  output logic              res_valid_o,
  input  logic              res_ready_i
);

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  // Saturation bounds for a value with 2*FRA_BW fraction bits: [-2^SatSh, 2^SatSh - 1].
  localparam int unsigned       SatSh   = INT_BW + 2 * FRA_BW;
  localparam logic [ACC_BW-1:0] SatHi   = {{(ACC_BW - SatSh){1'b0}}, {SatSh{1'b1}}};
  localparam logic [ACC_BW-1:0] SatLo   = ~SatHi;
  localparam logic [MUL_BW-1:0] MaxPos  = {1'b0, {(MUL_BW - 1){1'b1}}};
  localparam logic [MUL_BW-1:0] MaxNeg  = {1'b1, {(MUL_BW - 1){1'b0}}};
  localparam logic [CNT_BW-1:0] IterMax = CNT_BW'(ITER_MAX);
  localparam logic [CNT_BW-1:0] CntOne  = CNT_BW'(1);

  function automatic logic [ACC_BW-1:0] sext(input logic [MUL_BW-1:0] v);
    return {{(ACC_BW - MUL_BW){v[MUL_BW-1]}}, v};
  endfunction

  // Coefficient aligned to the accumulator's 2*FRA_BW fraction point.
  function automatic logic [ACC_BW-1:0] ext(input logic [MUL_BW-1:0] c);
    return sext(c) << FRA_BW;
  endfunction

  // Back to Q(INT_BW.FRA_BW); in-range values truncate toward minus infinity.
  function automatic logic [MUL_BW-1:0] sat(input logic [ACC_BW-1:0] a);
    if ($signed(a) > $signed(SatHi)) begin
      return MaxPos;
    end else if ($signed(a) < $signed(SatLo)) begin
      return MaxNeg;
    end else begin
      return a[MUL_BW+FRA_BW-1:FRA_BW];
    end
  endfunction

  state_e              state_q, state_d;
  logic [MUL_BW-1:0]   wreg_q, wreg_d;
  logic [MUL_BW-1:0]   ireg_q, ireg_d;
  logic [ACC_BW-1:0]   oreg_q, oreg_d;
  logic [MUL_BW-1:0]   xreg_q, xreg_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic [ACC_BW-1:0]   acc_q, acc_d;
  logic [MUL_BW-1:0]   res_q, res_d;
  logic [1:0]          res_op_q, res_op_d;

  logic                coef_hs;
  logic [ACC_BW-1:0]   horner_step;

  assign coef_hs     = coef_valid_i && coef_ready_o;
  // One Horner step: sat(acc) * x + c, all in ACC_BW two's-complement.
  assign horner_step = sext(sat(acc_q)) * sext(xreg_q) + ext(coef_i);

  // GEMM datapath: forwarding regs always run; the partial sum only updates while idle in gemm.
  always_comb begin
    wreg_d = wc_i;
    ireg_d = x_i;
    oreg_d = oreg_q;
    if (gemm_uno == 2'b00 && state_q == StIdle) begin
      oreg_d = sext(wreg_q) * sext(ireg_q) + o_i;
    end
  end

  // Horner FSM next state.
  always_comb begin
    state_d  = state_q;
    xreg_d   = xreg_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    res_d    = res_q;
    res_op_d = res_op_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && gemm_uno != 2'b00) begin
          xreg_d  = x_i;
          op_d    = gemm_uno;
          cnt_d   = (iters_i > IterMax) ? IterMax : iters_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (coef_hs) begin
          acc_d = ext(coef_i);
          if (cnt_q == '0) begin
            state_d  = StDone;
            res_d    = sat(ext(coef_i));
            res_op_d = op_q;
          end else begin
            state_d = StIter;
          end
        end
      end
      StIter: begin
        if (coef_hs) begin
          acc_d = horner_step;
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d  = StDone;
            res_d    = sat(horner_step);
            res_op_d = op_q;
          end
        end
      end
      StDone: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wreg_q   <= '0;
      ireg_q   <= '0;
      oreg_q   <= '0;
      xreg_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      res_op_q <= '0;
    end else begin
      state_q  <= state_d;
      wreg_q   <= wreg_d;
      ireg_q   <= ireg_d;
      oreg_q   <= oreg_d;
      xreg_q   <= xreg_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      res_op_q <= res_op_d;
    end
  end

  assign wc_o         = wreg_q;
  assign x_o          = ireg_q;
  assign o_o          = oreg_q;
  assign busy_o       = (state_q != StIdle);
  assign coef_ready_o = (state_q == StLoad) || (state_q == StIter);
  assign res_valid_o  = (state_q == StDone);
  // res_q/res_op_q are captured on entry to DONE so they hold until the next result.
  assign res_o        = res_q;
  assign res_op_o     = res_op_q;

endmodule

// File: tb/tb_pe_horner.sv
// Scoreboard bench for pe_horner: stimulus pushes expected results, a negedge monitor pops
// and compares them whenever a result is handed over.

module tb_pe_horner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  gemm_uno = 2'b00;
  logic [15:0] x_i = '0, wc_i = '0, coef_i = '0;
  logic [31:0] o_i = '0;
  logic [15:0] x_o, wc_o, res_o;
  logic [31:0] o_o;
  logic        start_i = 1'b0, coef_valid_i = 1'b0, res_ready_i = 1'b1;
  logic [3:0]  iters_i = '0;
  logic        busy_o, coef_ready_o, res_valid_o;
  logic [1:0]  res_op_o;

  pe_horner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gemm_uno     (gemm_uno),
    .x_i          (x_i),
    .wc_i         (wc_i),
    .o_i          (o_i),
    .x_o          (x_o),
    .wc_o         (wc_o),
    .o_o          (o_o),
    .start_i      (start_i),
    .iters_i      (iters_i),
    .busy_o       (busy_o),
    .coef_i       (coef_i),
    .coef_valid_i (coef_valid_i),
    .coef_ready_o (coef_ready_o),
    .res_o        (res_o),
    .res_op_o     (res_op_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [1:0]  op;
    int          hs;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          hs_cnt = 0;
  int          hs_base = 0;
  logic [15:0] ctab[0:15];
  int          ctab_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_zero(input string p);
    check({p, "_o_o"}, o_o, 32'h0);
    check({p, "_x_o"}, {16'h0, x_o}, 32'h0);
    check({p, "_wc_o"}, {16'h0, wc_o}, 32'h0);
    check({p, "_res_o"}, {16'h0, res_o}, 32'h0);
    check({p, "_res_op"}, {30'h0, res_op_o}, 32'h0);
    check({p, "_res_valid"}, {31'h0, res_valid_o}, 32'h0);
    check({p, "_busy"}, {31'h0, busy_o}, 32'h0);
    check({p, "_coef_ready"}, {31'h0, coef_ready_o}, 32'h0);
  endtask

  // Coefficient handshakes the DUT will take on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && coef_valid_i && coef_ready_o) hs_cnt++;
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", {31'h0, res_valid_o}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_res"}, {16'h0, res_o}, {16'h0, e.res});
        check({e.name, "_op"}, {30'h0, res_op_o}, {30'h0, e.op});
        check({e.name, "_hs"}, hs_cnt - hs_base, e.hs);
      end
    end
  end

  task automatic run_eval(input string name, input logic [1:0] op, input logic [15:0] x,
                          input logic [3:0] n, input logic [15:0] exp_res, input int exp_hs,
                          input bit gaps, input bit extra, input bit poke, input bit hold,
                          input bit chk_lat);
    int k;
    int lat;
    bit hs;
    @(posedge clk); #1;
    gemm_uno    = op;
    x_i         = x;
    iters_i     = n;
    start_i     = 1'b1;
    res_ready_i = !hold;
    hs_base     = hs_cnt;
    exp_q.push_back('{name: name, res: exp_res, op: op, hs: exp_hs});
    @(posedge clk); #1;
    start_i  = 1'b0;
    gemm_uno = ~op;  // must not leak into res_op_o
    k   = 0;
    lat = 1;
    for (int c = 0; c < 100 && !res_valid_o; c++) begin
      if (poke) begin
        start_i = (c == 1);
        if (c == 1) begin
          gemm_uno = 2'b11;
          x_i      = 16'h7C00;
        end
      end
      coef_valid_i = (k < ctab_n || extra) && !(gaps && ($urandom_range(0, 2) == 0));
      coef_i       = (k < ctab_n) ? ctab[k] : 16'h0400;
      hs           = coef_valid_i && coef_ready_o;
      @(posedge clk); #1;
      lat++;
      if (hs) k++;
    end
    coef_valid_i = 1'b0;
    start_i      = 1'b0;
    check({name, "_done"}, {31'h0, res_valid_o}, 32'h1);
    if (chk_lat) check({name, "_lat"}, lat, n + 2);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check({name, "_hold_valid"}, {31'h0, res_valid_o}, 32'h1);
        check({name, "_hold_res"}, {16'h0, res_o}, {16'h0, exp_res});
      end
      res_ready_i = 1'b1;
    end
    for (int c = 0; c < 10 && busy_o; c++) begin
      @(posedge clk); #1;
    end
    check({name, "_idle"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #3;
    check_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // GEMM: 1.0 * 2.0 in Q5.10 -> 2^21, plus o_i.
    gemm_uno = 2'b00; wc_i = 16'h0400; x_i = 16'h0800; o_i = 32'd5;
    @(posedge clk); #1;
    check("gemm_x_o", {16'h0, x_o}, 32'h0800);
    check("gemm_wc_o", {16'h0, wc_o}, 32'h0400);
    check("gemm_o_lat1", o_o, 32'h5);
    @(posedge clk); #1;
    check("gemm_prod", o_o, 32'h0020_0005);
    gemm_uno = 2'b01; wc_i = 16'hFC00; o_i = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("gemm_hold", o_o, 32'h0020_0005);
    gemm_uno = 2'b00; wc_i = 16'hFC00; x_i = 16'h0800; o_i = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("gemm_neg", o_o, 32'hFFE0_0010);
    wc_i = 16'h0400; x_i = 16'h0400; o_i = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("gemm_wrap", o_o, 32'h800F_FFFF);

    // 1 + 0.5 + 0.25 = 1.75
    ctab[0] = 16'h0400; ctab[1] = 16'h0400; ctab[2] = 16'h0400; ctab_n = 3;
    run_eval("horner", 2'b10, 16'h0200, 4'd2, 16'h0700, 3, 0, 0, 0, 0, 1);

    ctab[0] = 16'h7C00; ctab[1] = 16'h7C00; ctab_n = 2;
    run_eval("sat_hi", 2'b01, 16'h7C00, 4'd1, 16'h7FFF, 2, 0, 0, 0, 0, 1);

    ctab[0] = 16'h8400; ctab[1] = 16'h8000; ctab_n = 2;
    run_eval("sat_lo", 2'b11, 16'h7C00, 4'd1, 16'h8000, 2, 0, 0, 0, 0, 0);

    ctab[0] = 16'hFC00; ctab_n = 1;
    run_eval("deg0", 2'b10, 16'h1234, 4'd0, 16'hFC00, 1, 0, 1, 0, 0, 1);

    // Clamped to degree 8: nine coefficients of 0.125 times x = 1.0 -> 1.125
    for (int i = 0; i < 9; i++) ctab[i] = 16'h0080;
    ctab_n = 9;
    run_eval("deg15", 2'b01, 16'h0400, 4'd15, 16'h0480, 9, 0, 1, 0, 0, 0);

    ctab[0] = 16'h0400; ctab[1] = 16'h0400; ctab[2] = 16'h0400; ctab_n = 3;
    run_eval("gaps", 2'b10, 16'h0200, 4'd2, 16'h0700, 3, 1, 0, 0, 0, 0);
    run_eval("stall", 2'b10, 16'h0200, 4'd2, 16'h0700, 3, 0, 0, 0, 1, 0);
    run_eval("busy_start", 2'b10, 16'h0200, 4'd2, 16'h0700, 3, 0, 0, 1, 0, 0);

    // Abort an evaluation in ITER with a one-cycle asynchronous reset.
    @(posedge clk); #1;
    gemm_uno = 2'b01; x_i = 16'h0200; wc_i = 16'h0400; iters_i = 4'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; coef_valid_i = 1'b1; coef_i = 16'h0400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0; coef_valid_i = 1'b0;
    #2;
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_eval("post_rst", 2'b10, 16'h0200, 4'd2, 16'h0700, 3, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_horner.md
Name: pe_horner

Overview:
- Next-generation processing element for the systolic array.
- GEMM mode: weight-stationary-style multiply-accumulate with pass-through of weight and activation to the neighbouring PEs.
- Unary modes (div/exp/log): a multi-cycle Horner polynomial engine. Coefficients stream in over a valid/ready handshake, so approximation degree is a runtime choice and no fixed scale/offset generator is needed.
- Saturation to the Q(INT_BW.FRA_BW) format is part of every iteration.

Parameters:
- INT_BW, 5: integer bits of the signed fixed-point operand.
- FRA_BW, 10: fraction bits of the operand.
- MUL_BW, 16: operand width; must equal 1+INT_BW+FRA_BW.
- ACC_BW, 32: accumulator width; must be at least 2*MUL_BW.
- ITER_MAX, 8: maximum polynomial degree.
- CNT_BW, $clog2(ITER_MAX+1): width of the degree input and the iteration counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- gemm_uno  in  2  mode select: 00 gemm, 01 div, 10 exp, 11 log
- x_i  in  MUL_BW  activation (gemm) or polynomial argument x (unary), signed
- wc_i  in  MUL_BW  weight in, signed
- o_i  in  ACC_BW  partial sum in, signed
- x_o  out  MUL_BW  registered activation to neighbour
- wc_o  out  MUL_BW  registered weight to neighbour
- o_o  out  ACC_BW  registered partial sum out
- start_i  in  1  start a unary evaluation
- iters_i  in  CNT_BW  polynomial degree N
- busy_o  out  1  high whenever the FSM is not IDLE
- coef_i  in  MUL_BW  coefficient in Q format, highest order first
- coef_valid_i  in  1  coefficient valid
- coef_ready_o  out  1  coefficient accepted when valid and ready are both high
- res_o  out  MUL_BW  saturated unary result
- res_op_o  out  2  latched gemm_uno of the evaluation that produced res_o
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed

Behaviour:
- Reset: every register and output is 0, FSM is IDLE.
- GEMM path, active every cycle regardless of FSM state:
  - wreg<=wc_i, ireg<=x_i; wc_o=wreg, x_o=ireg.
- Partial sum:
  - When gemm_uno==00 and FSM is IDLE: oreg <= sext(wreg)*sext(ireg)+o_i, computed in ACC_BW with two's-complement wrap.
  - Otherwise oreg holds.
  - o_o=oreg. Latency from wc_i/x_i to o_o is 2 cycles; from o_i to o_o is 1 cycle.
- sat(a) converts ACC_BW with 2*FRA_BW fraction bits to MUL_BW:
  - If a > 2^(INT_BW+2*FRA_BW)-1, result is 0x7FFF.
  - If a < -2^(INT_BW+2*FRA_BW), result is 0x8000.
  - Otherwise result is a[MUL_BW+FRA_BW-1:FRA_BW] (truncation toward minus infinity).
- Coefficient alignment: ext(c) = sext(c)<<FRA_BW.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - start_i && gemm_uno!=00: latch xreg=x_i, op=gemm_uno, cnt=min(iters_i, ITER_MAX); go to LOAD.
  - start_i with gemm_uno==00 is ignored.
- LOAD:
  - coef_ready_o=1.
  - On handshake: acc<=ext(coef_i); go to DONE if cnt==0, else ITER.
- ITER:
  - coef_ready_o=1.
  - On handshake: acc<=sext(sat(acc))*sext(xreg)+ext(coef_i); cnt<=cnt-1; go to DONE when cnt==1.
- LOAD and ITER stall with no state change while coef_valid_i is low.
- DONE:
  - res_valid_o=1, res_o=sat(acc), res_op_o=op.
  - On res_ready_i go to IDLE.
  - res_o and res_op_o hold until the next DONE.
- coef_ready_o is 0 in IDLE and DONE.
- Degree N accepts exactly N+1 coefficients.
- With coef_valid_i continuously high, res_valid_o rises N+2 cycles after the start cycle.
- start_i is ignored while busy; gemm_uno changes while busy do not affect the latched op.
- Asynchronous reset mid-evaluation aborts it: FSM to IDLE, res_valid_o=0, acc=0.

Test Plan:
- GEMM product: wc_i=0x0400, x_i=0x0800, o_i=5 held -> o_o=0x00200005 two cycles after applied. Then gemm_uno=01 with start_i=0 -> o_o holds 0x00200005.
- Horner, unstalled: gemm_uno=10, x_i=0x0200, N=2, coefs 0x0400,0x0400,0x0400 with valid always high -> res_o=0x0700, res_op_o=10, res_valid_o high 4 cycles after start.
- Saturation: x=0x7C00, N=1, coefs 0x7C00,0x7C00 -> res_o=0x7FFF. Same with the second coefficient 0x8000 and x=0x7C00, first coefficient 0x8400 -> res_o=0x8000.
- Degree handling:
  - N=0, single coef 0xFC00 -> res_o=0xFC00, and exactly 1 coef handshake.
  - iters_i=15 with ITER_MAX=8 -> exactly 9 handshakes.
- Backpressure:
  - Random coef_valid_i gaps -> same result as the unstalled run (0x0700).
  - res_ready_i low for 5 cycles -> res_valid_o and res_o stable.
  - start_i during busy -> ignored.
- Reset mid-ITER: rst_n low for 1 cycle -> all outputs 0, busy_o=0. A new start then produces a correct result.
